// File: rtl/reg8_wbuf.sv
// Byte write buffer in front of reg8: valid/ready in, one write per clock out, stalls on hold.
// Optional zero-latency pass-through when empty is enabled by defining REG8_WBUF_BYPASS_EN.
module reg8_wbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    input  logic [WIDTH-1:0]         i_in_data,
    output logic                     o_in_ready,
    input  logic                     i_hold,
    output logic                     o_we,
    output logic [WIDTH-1:0]         o_wdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_byp;

    // Occupancy comes only from the counter; pointers alone cannot tell full from empty.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && !i_hold && !i_flush;

`ifdef REG8_WBUF_BYPASS_EN
    assign w_byp = w_empty && !i_hold && !i_flush && i_in_valid;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed byte goes straight to reg8 and never occupies a slot.
    assign w_push = i_in_valid && !w_full && !i_flush && !w_byp;

    assign o_in_ready = !w_full;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_we       = w_pop || w_byp;
    assign o_wdata    = w_byp ? i_in_data : (w_empty ? '0 : r_mem[r_rd_ptr]);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_reg8_wbuf.sv
// Scoreboard bench for reg8_wbuf: a tracker enqueues accepted bytes, a monitor checks every cycle.
module tb_reg8_wbuf;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             hold = 1'b0;
    logic             in_ready;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [$clog2(DEPTH):0] count;
    logic             empty;
    logic             full;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    int m_pre = 0;
    bit m_byp = 1'b0;
    logic [WIDTH-1:0] sb [$];

    reg8_wbuf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .i_in_data(in_data), .o_in_ready(in_ready), .i_hold(hold), .o_we(we),
        .o_wdata(wdata), .o_count(count), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            int  pre;
            bit  exp_we;
            bit  byp;
            logic [WIDTH-1:0] head;
            pre = sb.size();
            byp = 1'b0;
`ifdef REG8_WBUF_BYPASS_EN
            byp = (pre == 0) && !hold && !flush && in_valid;
`endif
            exp_we = ((pre > 0) && !hold && !flush) || byp;
            check("count", int'(count), pre);
            check("empty", int'(empty), int'(pre == 0));
            check("full", int'(full), int'(pre == DEPTH));
            check("in_ready", int'(in_ready), int'(pre < DEPTH));
            check("we", int'(we), int'(exp_we));
            if (we === 1'b1) begin
                if (byp) begin
                    check("wdata_bypass", int'(wdata), int'(in_data));
                end else if (pre > 0) begin
                    head = sb.pop_front();
                    check("wdata", int'(wdata), int'(head));
                end
            end else if (pre == 0) begin
                check("wdata_idle", int'(wdata), 0);
            end
            m_pre = pre;
            m_byp = byp;
        end
    end

    // Tracker: at the commit edge, record what the buffer must have accepted.
    always @(posedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else if (in_valid && (m_pre < DEPTH) && !m_byp) begin
            sb.push_back(in_data);
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic h,
                        input logic f, input logic r);
        @(posedge clk);
        #1;
        armed    = 1'b1;
        in_valid = v;
        in_data  = d;
        hold     = h;
        flush    = f;
        rst      = r;
    endtask

    initial begin
        logic [WIDTH-1:0] fill [5];
        fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset: queue three bytes, reset, then idle must stay quiet.
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h02, 1, 0, 0);
        step(1, 8'h03, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Single write.
        step(1, 8'hAA, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Fill under hold; fifth byte waits until a slot frees.
        for (int i = 0; i < 5; i++) step(1, fill[i], 1, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0, 0);

        // Two queued, then streaming push+pop holds count at 2 across pointer wraps.
        step(1, 8'hC0, 1, 0, 0);
        step(1, 8'hC1, 1, 0, 0);
        for (int i = 2; i < 12; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0);

        // Flush with three queued and a concurrent byte.
        step(1, 8'hE1, 1, 0, 0);
        step(1, 8'hE2, 1, 0, 0);
        step(1, 8'hE3, 1, 0, 0);
        step(1, 8'h99, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0), 0, 0);
        end
        for (int i = 0; i < DEPTH + 3; i++) step(0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #1;
        check("drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg8_wbuf.md
# reg8_wbuf

Byte write buffer sitting directly upstream of the `reg8` storage register. Accepts a stream of byte writes over a valid/ready handshake, queues them in a small FIFO, and drains one entry per clock onto the `reg8` `wdata`/`we` inputs, stalling while the downstream `hold` is asserted. Decouples bursty producers from the register update path and gives in-order, lossless delivery.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries. Power of two, at least 2.
- `WIDTH`, default 8: data width. Matches the `reg8` `wdata` width.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous discard of all queued entries.
- `in_valid` in 1: producer has a byte write.
- `in_data` in WIDTH: write data.
- `in_ready` out 1: buffer accepts. Equals `!full`.
- `hold` in 1: downstream stall. While high, no write is issued.
- `we` out 1: write enable to `reg8`.
- `wdata` out WIDTH: write data to `reg8`.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.

## Operation
- **Storage:** circular buffer with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate `count` register. `full` and `empty` derive from `count`, never from pointer compare.
- **Push:** occurs at an edge where `in_valid && in_ready && !flush && !rst`. Writes `mem[wr_ptr]` and increments `wr_ptr`.
- **Issue (combinational from state):**
  - `we = !empty && !hold && !flush`.
  - `wdata = empty ? 0 : mem[rd_ptr]`.
- **Pop:** occurs at an edge where `we` is 1. Increments `rd_ptr`.
- **Count update:** +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Push when full:** `in_ready` is 0 even if a pop happens the same cycle. The producer must hold `in_valid`/`in_data` until accepted.
- **Pop when empty:** impossible, since `we` is 0.
- **Flush:** clears pointers and `count` at the edge. A push in the same cycle is dropped, and `we` is 0 during the flush cycle.
- **Priority:** `rst` > `flush` > push/pop.
- **Reset values:**
  - `count`=0, `empty`=1, `full`=0, `in_ready`=1.
  - `we`=0, `wdata`=0.
  - Pointers are 0. `mem` contents are not reset.
- **Ordering:** entries leave strictly in acceptance order. No entry is lost or duplicated except by `flush`/`rst`.

## Timing
- **Latency (macro off):** a byte accepted at edge E drives `we`=1/`wdata` during cycle E..E+1 if `hold`=0, and `reg8` captures it at edge E+1. Each `hold` cycle adds one cycle.
- **Throughput:** one write per clock in and out, sustained with `hold`=0 and the buffer never filling.
- **`hold` timing:** sampled combinationally. Asserting `hold` in a cycle suppresses that cycle's `we` and pop.
- **Reset or flush mid-burst:** takes effect at the edge it is sampled. Outputs show reset/empty values from the next cycle. `in_ready` is 1 the cycle after.

## Configuration
- `REG8_WBUF_BYPASS_EN` defined: when `empty && !hold && !flush && in_valid`:
  - `we`=1 and `wdata=in_data` in the same cycle (zero latency).
  - The byte is consumed without being enqueued; no push and no pop.
  - If `hold`=1, the byte is enqueued normally.
- Undefined: every byte passes through the FIFO, with minimum latency of one edge.

## Test plan
- **Reset:** push 3 bytes, assert `rst` one cycle → `count`=0, `empty`=1, `we`=0, `wdata`=0, `in_ready`=1 at the following cycle. No further writes are issued.
- **Single write:** `hold`=0, push 0xAA at edge E → `we`=1, `wdata`=0xAA during the next cycle, `reg8` `rdata`=0xAA after edge E+1, then `empty`=1. With the bypass macro, `we`=1 in the push cycle instead.
- **Fill/stall:** `hold`=1, push 0x11,0x22,0x33,0x44 → `full`=1, `in_ready`=0, and a fifth byte 0x55 is held off. Release `hold` → writes 0x11,0x22,0x33,0x44 on consecutive cycles, then 0x55, in order.
- **Simultaneous push/pop at count 2:** `count` stays 2. Pointers wrap past DEPTH−1 and data order is preserved across the wrap.
- **Flush:** with 3 entries queued and `in_valid`=1 on the flush cycle → `we`=0 that cycle, and `count`=0 after the edge. The concurrent byte is dropped.
- **Random:** 200 random `in_valid`/`in_data`/`hold` cycles checked against a scoreboard queue. Every `we` cycle must match the scoreboard head, and `count` must match the scoreboard size.
